// File: rtl/reg_write_scheduler.sv
// Arbitrates three register-file write requesters and runs a bulk clear sweep; writes land one cycle after accept.
// Optional macro REG_WR_ROUND_ROBIN_EN selects round-robin grant; default is fixed priority 0 > 1 > 2.
module reg_write_scheduler #(
    parameter int NUM_REGS  = 100,
    parameter int PROT_REGS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    output logic [2:0]  req_ready,
    input  logic [7:0]  req_addr_0,
    input  logic [7:0]  req_addr_1,
    input  logic [7:0]  req_addr_2,
    input  logic [63:0] req_data_0,
    input  logic [63:0] req_data_1,
    input  logic [63:0] req_data_2,
    output logic [7:0]  reg_write_addr,
    output logic [63:0] reg_write_data,
    output logic        reg_write_cmd,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        err_valid,
    output logic [7:0]  err_addr,
    output logic [1:0]  err_src
);

    typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [8:0] NUM_L  = 9'(NUM_REGS);
    localparam logic [8:0] PROT_L = 9'(PROT_REGS);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        cmd_q, cmd_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        errv_q, errv_d;
    logic [7:0]  erra_q, erra_d;
    logic [1:0]  errs_q, errs_d;

    logic [2:0]  grant;
    logic        accept;
    logic [1:0]  sel_idx;
    logic [7:0]  sel_addr;
    logic [63:0] sel_data;
    logic        legal;

`ifdef REG_WR_ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;

    // Search starts just after the last granted requester and wraps.
    always_comb begin
        grant = 3'b000;
        case (last_q)
            2'd0: begin
                if (req_valid[1])      grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
            end
            2'd1: begin
                if (req_valid[2])      grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
            end
            default: begin
                if (req_valid[0])      grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
            end
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept) last_d = sel_idx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_q <= 2'd2;
        else       last_q <= last_d;
    end
`else
    always_comb begin
        grant = 3'b000;
        if (req_valid[0])      grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
    end
`endif

    assign req_ready = (state_q == ARB && !clear_start) ? grant : 3'b000;
    assign accept    = |req_ready;

    always_comb begin
        sel_idx  = 2'd0;
        sel_addr = req_addr_0;
        sel_data = req_data_0;
        if (req_ready[1]) begin
            sel_idx  = 2'd1;
            sel_addr = req_addr_1;
            sel_data = req_data_1;
        end else if (req_ready[2]) begin
            sel_idx  = 2'd2;
            sel_addr = req_addr_2;
            sel_data = req_data_2;
        end
    end

    assign legal = ({1'b0, sel_addr} >= PROT_L) && ({1'b0, sel_addr} < NUM_L);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        errv_d  = 1'b0;
        erra_d  = 8'd0;
        errs_d  = 2'd0;
        case (state_q)
            ARB: begin
                busy_d = 1'b0;
                if (clear_start) begin
                    // First sweep write is registered now so it is visible in the first CLEAR cycle.
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    cmd_d   = 1'b1;
                    waddr_d = PROT_L[7:0];
                    wdata_d = 64'd0;
                    cnt_d   = PROT_L + 9'd1;
                end else if (accept) begin
                    if (legal) begin
                        cmd_d   = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                    end else begin
                        errv_d = 1'b1;
                        erra_d = sel_addr;
                        errs_d = sel_idx;
                    end
                end
            end
            default: begin
                busy_d = 1'b1;
                if (cnt_q >= NUM_L) begin
                    state_d = ARB;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = PROT_L;
                end else begin
                    cmd_d   = 1'b1;
                    waddr_d = cnt_q[7:0];
                    wdata_d = 64'd0;
                    cnt_d   = cnt_q + 9'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            cnt_q   <= PROT_L;
            cmd_q   <= 1'b0;
            waddr_q <= 8'd0;
            wdata_q <= 64'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            errv_q  <= 1'b0;
            erra_q  <= 8'd0;
            errs_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            errv_q  <= errv_d;
            erra_q  <= erra_d;
            errs_q  <= errs_d;
        end
    end

    assign reg_write_cmd  = cmd_q;
    assign reg_write_addr = waddr_q;
    assign reg_write_data = wdata_q;
    assign clear_busy     = busy_q;
    assign clear_done     = done_q;
    assign err_valid      = errv_q;
    assign err_addr       = erra_q;
    assign err_src        = errs_q;

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench for reg_write_scheduler: single write, contention, illegal writes, clear sweep, reset mid-clear.
module tb_reg_write_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = 3'b000;
    logic [2:0]  req_ready;
    logic [7:0]  req_addr_0 = 8'd0, req_addr_1 = 8'd0, req_addr_2 = 8'd0;
    logic [63:0] req_data_0 = 64'd0, req_data_1 = 64'd0, req_data_2 = 64'd0;
    logic [7:0]  reg_write_addr;
    logic [63:0] reg_write_data;
    logic        reg_write_cmd;
    logic        clear_start = 1'b0;
    logic        clear_busy, clear_done;
    logic        err_valid;
    logic [7:0]  err_addr;
    logic [1:0]  err_src;

    int vectors = 0;
    int miscompares = 0;

    reg_write_scheduler #(.NUM_REGS(100), .PROT_REGS(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1), .req_addr_2(req_addr_2),
        .req_data_0(req_data_0), .req_data_1(req_data_1), .req_data_2(req_data_2),
        .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .reg_write_cmd(reg_write_cmd),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .err_valid(err_valid), .err_addr(err_addr), .err_src(err_src)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cmd"},   64'(reg_write_cmd),  64'd0);
        check({tag, " addr"},  64'(reg_write_addr), 64'd0);
        check({tag, " data"},  reg_write_data,      64'd0);
        check({tag, " busy"},  64'(clear_busy),     64'd0);
        check({tag, " done"},  64'(clear_done),     64'd0);
        check({tag, " errv"},  64'(err_valid),      64'd0);
        check({tag, " erra"},  64'(err_addr),       64'd0);
        check({tag, " errs"},  64'(err_src),        64'd0);
        check({tag, " ready"}, 64'(req_ready),      64'd0);
    endtask

    logic [2:0] exp_grant [6];
    logic [7:0] exp_addr  [6];

    initial begin
`ifdef REG_WR_ROUND_ROBIN_EN
        exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_addr  = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12};
`else
        exp_grant = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        exp_addr  = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
`endif

        // Reset state
        #3;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Single write
        req_valid  = 3'b001;
        req_addr_0 = 8'd5;
        req_data_0 = 64'hDEAD;
        #1;
        check("single ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        check("single cmd",  64'(reg_write_cmd),  64'd1);
        check("single addr", 64'(reg_write_addr), 64'd5);
        check("single data", reg_write_data,      64'hDEAD);
        tick();
        check("single cmd drop", 64'(reg_write_cmd), 64'd0);

        // Re-reset so the arbitration pointer starts from "last granted = 2"
        reset = 1'b1;
        #1;
        reset = 1'b0;

        // Contention
        req_addr_0 = 8'd10; req_data_0 = 64'hA0;
        req_addr_1 = 8'd11; req_data_1 = 64'hA1;
        req_addr_2 = 8'd12; req_data_2 = 64'hA2;
        req_valid  = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont ready %0d", i), 64'(req_ready), 64'(exp_grant[i]));
            tick();
            check($sformatf("cont cmd %0d", i),  64'(reg_write_cmd),  64'd1);
            check($sformatf("cont addr %0d", i), 64'(reg_write_addr), 64'(exp_addr[i]));
            check($sformatf("cont data %0d", i), reg_write_data, 64'hA0 + 64'(exp_addr[i] - 8'd10));
        end
        req_valid = 3'b000;
        tick();

        // Protected and out-of-range writes
        req_valid  = 3'b010;
        req_addr_1 = 8'd1;
        #1;
        check("prot ready", 64'(req_ready), 64'b010);
        tick();
        check("prot cmd",  64'(reg_write_cmd), 64'd0);
        check("prot errv", 64'(err_valid),     64'd1);
        check("prot erra", 64'(err_addr),      64'd1);
        check("prot errs", 64'(err_src),       64'd1);
        req_valid  = 3'b100;
        req_addr_2 = 8'd100;
        #1;
        check("oor ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = 3'b000;
        check("oor cmd",  64'(reg_write_cmd), 64'd0);
        check("oor errv", 64'(err_valid),     64'd1);
        check("oor erra", 64'(err_addr),      64'd100);
        check("oor errs", 64'(err_src),       64'd2);
        tick();
        check("err pulse end", 64'(err_valid),     64'd0);
        check("err no cmd",    64'(reg_write_cmd), 64'd0);

        // Clear sweep with all requesters pending
        req_valid   = 3'b111;
        clear_start = 1'b1;
        #1;
        check("clear start ready", 64'(req_ready), 64'b000);
        tick();
        clear_start = 1'b0;
        for (int a = 2; a < 100; a++) begin
            check($sformatf("clr ready %0d", a), 64'(req_ready),      64'd0);
            check($sformatf("clr cmd %0d", a),   64'(reg_write_cmd),  64'd1);
            check($sformatf("clr addr %0d", a),  64'(reg_write_addr), 64'(a));
            check($sformatf("clr data %0d", a),  reg_write_data,      64'd0);
            check($sformatf("clr busy %0d", a),  64'(clear_busy),     64'd1);
            check($sformatf("clr done %0d", a),  64'(clear_done),     64'd0);
            clear_start = (a == 50);
            tick();
        end
        clear_start = 1'b0;
        check("clr done pulse", 64'(clear_done),    64'd1);
        check("clr busy low",   64'(clear_busy),    64'd0);
        check("clr cmd end",    64'(reg_write_cmd), 64'd0);
        check("arb resume ready", 64'(req_ready),   64'b001);
        tick();
        req_valid = 3'b000;
        check("arb resume cmd",  64'(reg_write_cmd),  64'd1);
        check("arb resume addr", 64'(reg_write_addr), 64'd10);
        check("arb resume data", reg_write_data,      64'hA0);
        check("done one cycle",  64'(clear_done),     64'd0);
        tick();

        // Reset in the middle of a sweep
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 38; k++) tick();
        check("mid addr 40", 64'(reg_write_addr), 64'd40);
        check("mid busy",    64'(clear_busy),     64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("post rst done %0d", k), 64'(clear_done),    64'd0);
            check($sformatf("post rst cmd %0d", k),  64'(reg_write_cmd), 64'd0);
            check($sformatf("post rst busy %0d", k), 64'(clear_busy),    64'd0);
        end
        req_valid  = 3'b001;
        req_addr_0 = 8'd7;
        req_data_0 = 64'h77;
        #1;
        check("post rst ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        check("post rst wcmd",  64'(reg_write_cmd),  64'd1);
        check("post rst waddr", 64'(reg_write_addr), 64'd7);
        check("post rst wdata", reg_write_data,      64'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
